arb_burst_reader: RTL and testbench

//  Upstream requester for one port of the priority arbiter: on a start pulse it reads COUNT

---
 rtl/arb_burst_reader_pkg.sv | 15 +
 rtl/arb_burst_reader_if.sv | 16 +
 rtl/arb_burst_reader_sync_fifo.sv | 51 +++++
 rtl/arb_burst_reader.sv | 170 +++++++++++++++++
 tb/tb_arb_burst_reader.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_burst_reader_pkg.sv
// Shared types for the arbiter burst reader: FSM state encoding and gap timing.
package arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GAP,
    HOLD,
    DRAIN
  } arb_rd_state_e;

  // Idle cycles after each grant before req may rise again.
  localparam int ARB_GAP_CYCLES = 1;

endpackage

// File: rtl/arb_burst_reader_if.sv
// Arbiter port bundle: request/grant/read-data handshake between a requester and the arbiter.
interface arb_burst_reader_if #(
  parameter int AN = 23,
  parameter int DN = 16
);
  logic          req;
  logic [AN-1:0] addr;
  logic [DN-1:0] data;
  logic          wr;
  logic          ack;
  logic          valid;
  logic [DN-1:0] mem;

  modport master (output req, addr, data, wr, input ack, valid, mem);
  modport slave  (input req, addr, data, wr, output ack, valid, mem);
endinterface

// File: rtl/arb_burst_reader_sync_fifo.sv
// First-word-fall-through synchronous FIFO; DEPTH must be a power of two.
module sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   push,
  input  logic [DATA_W-1:0]      din,
  input  logic                   pop,
  output logic [DATA_W-1:0]      dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; only pointers and level define contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/arb_burst_reader.sv
// Burst read requester for one arbiter port, buffering returned words in a local FIFO.
// Optional ring addressing when ARB_RD_RING_EN is defined (adds ring_base/ring_words ports).
module arb_burst_reader
  import arb_pkg::*;
#(
  parameter int AN    = 23,
  parameter int DN    = 16,
  parameter int CN    = 16,
  parameter int DEPTH = 8
) (
  input  logic          clkSYS,
  input  logic          n_reset,
  input  logic          start,
  input  logic [AN-1:0] base_addr,
  input  logic [CN-1:0] count,
`ifdef ARB_RD_RING_EN
  input  logic [AN-1:0] ring_base,
  input  logic [AN-1:0] ring_words,
`endif
  output logic          busy,
  output logic          done,
  arb_burst_reader_if.master arb,
  output logic [DN-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);
  localparam int LW = $clog2(DEPTH) + 1;

  arb_rd_state_e state;
  logic [AN-1:0] cur_addr;
  logic [AN-1:0] next_addr;
  logic [AN-1:0] addr_q;
  logic          req_q;
  logic [CN-1:0] cnt_q;
  logic [CN-1:0] issued;
  logic [CN-1:0] received;
  logic [LW-1:0] outstanding;
  logic [LW-1:0] level;
  logic [LW:0]   inflight;
  logic [1:0]    gap_cnt;
  logic          credit;
  logic          push;
  logic          pop;
  logic          take_ack;
  logic          fifo_empty;
  logic          fifo_full;

`ifdef ARB_RD_RING_EN
  logic [AN-1:0] ring_last;
  assign ring_last = ring_base + ring_words - 1'b1;
  assign next_addr = (cur_addr == ring_last) ? ring_base : cur_addr + 1'b1;
`else
  assign next_addr = cur_addr + 1'b1;
`endif

  // Reserve FIFO space for every read in flight so returned data always fits.
  assign inflight = {1'b0, level} + {1'b0, outstanding};
  assign credit   = (inflight < (LW+1)'(DEPTH));
  assign take_ack = arb.ack & (state == REQ);
  assign push     = arb.valid & (state != IDLE) & ~fifo_full;
  assign pop      = out_valid & out_ready;

  assign arb.req   = req_q;
  assign arb.addr  = addr_q;
  assign arb.data  = '0;
  assign arb.wr    = 1'b0;
  assign out_valid = ~fifo_empty;

  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      cur_addr    <= '0;
      cnt_q       <= '0;
      issued      <= '0;
      received    <= '0;
      outstanding <= '0;
      gap_cnt     <= '0;
    end else begin
      done <= 1'b0;
      case ({take_ack, push})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (push) received <= received + 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            if (count == '0) begin
              done <= 1'b1;
            end else begin
              busy     <= 1'b1;
              cnt_q    <= count;
              cur_addr <= base_addr;
              issued   <= '0;
              received <= '0;
              if (credit) begin
                state  <= REQ;
                req_q  <= 1'b1;
                addr_q <= base_addr;
              end else begin
                state <= HOLD;
              end
            end
          end
        end
        REQ: begin
          if (arb.ack) begin
            req_q    <= 1'b0;
            cur_addr <= next_addr;
            issued   <= issued + 1'b1;
            gap_cnt  <= '0;
            state    <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == 2'(ARB_GAP_CYCLES - 1)) begin
            if ((issued < cnt_q) && credit) begin
              state  <= REQ;
              req_q  <= 1'b1;
              addr_q <= cur_addr;
            end else begin
              state <= HOLD;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (issued == cnt_q) begin
            state <= DRAIN;
          end else if (credit) begin
            state  <= REQ;
            req_q  <= 1'b1;
            addr_q <= cur_addr;
          end
        end
        DRAIN: begin
          if (received == cnt_q) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .DATA_W(DN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clkSYS),
    .n_reset(n_reset),
    .push   (push),
    .din    (arb.mem),
    .pop    (pop),
    .dout   (out_data),
    .level  (level),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

endmodule

// File: tb/tb_arb_burst_reader.sv
// Directed bench for arb_burst_reader: behavioural arbiter/memory model plus table-driven bursts.
module tb_arb_burst_reader;
  localparam int AN = 23;
  localparam int DN = 16;
  localparam int CN = 16;
  localparam int DEPTH = 8;

  logic          clk;
  logic          n_reset;
  logic          start;
  logic [AN-1:0] base_addr;
  logic [CN-1:0] count;
  logic          busy;
  logic          done;
  logic [DN-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
`ifdef ARB_RD_RING_EN
  logic [AN-1:0] ring_base;
  logic [AN-1:0] ring_words;
`endif

  arb_burst_reader_if #(.AN(AN), .DN(DN)) bus ();

  arb_burst_reader #(.AN(AN), .DN(DN), .CN(CN), .DEPTH(DEPTH)) dut (
    .clkSYS   (clk),
    .n_reset  (n_reset),
    .start    (start),
    .base_addr(base_addr),
    .count    (count),
`ifdef ARB_RD_RING_EN
    .ring_base (ring_base),
    .ring_words(ring_words),
`endif
    .busy     (busy),
    .done     (done),
    .arb      (bus),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Arbiter/memory model and output monitor, evaluated just after each falling edge.
  int ack_dly = 2;
  int val_dly = 3;
  int cyc = 0, done_cnt = 0, age = 0, run = 0, last_run = 0, unstable = 0;
  int gap_meas = -1, last_ack_cyc = 0;
  bit prev_req = 0, prev_ack = 0, have_ack = 0, req_seen = 0, busy_seen = 0;
  logic [AN-1:0] run_addr;
  logic [AN-1:0] grants[$];
  logic [DN-1:0] got[$];
  int            pend_due[$];
  logic [AN-1:0] pend_addr[$];

  always @(negedge clk) begin
    logic [AN-1:0] a;
    #1;
    cyc++;
    if (out_valid && out_ready) got.push_back(out_data);
    if (done) done_cnt++;
    if (busy) busy_seen = 1;
    if (bus.req) begin
      req_seen = 1;
      if (!prev_req || prev_ack) begin
        if (!prev_req && have_ack) begin
          gap_meas = cyc - last_ack_cyc - 1;
          have_ack = 0;
        end
        run = 1;
        run_addr = bus.addr;
      end else begin
        run++;
        if (bus.addr !== run_addr) unstable++;
      end
    end
    prev_req = bus.req;
    bus.ack = 1'b0;
    bus.valid = 1'b0;
    if (bus.req && !prev_ack) begin
      age++;
      if (age >= ack_dly) begin
        bus.ack = 1'b1;
        grants.push_back(bus.addr);
        pend_due.push_back(cyc + val_dly);
        pend_addr.push_back(bus.addr);
        age = 0;
        last_run = run;
        last_ack_cyc = cyc;
        have_ack = 1;
      end
    end else begin
      age = 0;
    end
    prev_ack = bus.ack;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      void'(pend_due.pop_front());
      a = pend_addr.pop_front();
      bus.valid = 1'b1;
      bus.mem = a[15:0] ^ 16'h5A5A;
    end
  end

  task automatic do_start(input logic [AN-1:0] b, input logic [CN-1:0] c);
    @(negedge clk);
    base_addr = b;
    count = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", done_cnt, target);
    repeat (DEPTH + 2) @(negedge clk);
  endtask

  task automatic check_burst(input string tag, input logic [AN-1:0] b, input int n);
    int ae = 0, de = 0;
    logic [AN-1:0] ea;
    logic [DN-1:0] ed;
    for (int i = 0; i < n; i++) begin
      ea = b + AN'(i);
      ed = ea[15:0] ^ 16'h5A5A;
      if (i >= grants.size() || grants[i] !== ea) ae++;
      if (i >= got.size() || got[i] !== ed) de++;
    end
    chk({tag, "_grants"}, grants.size(), n);
    chk({tag, "_words"}, got.size(), n);
    chk({tag, "_addr_err"}, ae, 0);
    chk({tag, "_data_err"}, de, 0);
  endtask

  typedef struct {
    logic [AN-1:0] base;
    logic [CN-1:0] cnt;
    int            ackd;
    int            vald;
    logic [AN-1:0] exp_first;
    logic [AN-1:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [AN-1:0] fa, la;
    vecs[0] = '{23'h000100, 16'd4, 2, 3, 23'h000100, 23'h000103};
    vecs[1] = '{23'h7FFFFE, 16'd4, 2, 2, 23'h7FFFFE, 23'h000001};
    vecs[2] = '{23'h002000, 16'd1, 2, 5, 23'h002000, 23'h002000};
    vecs[3] = '{23'h000055, 16'd9, 2, 6, 23'h000055, 23'h00005D};
    vecs[4] = '{23'h003FF0, 16'd3, 4, 1, 23'h003FF0, 23'h003FF2};

    n_reset = 1'b0;
    start = 1'b0;
    base_addr = '0;
    count = '0;
    out_ready = 1'b1;
`ifdef ARB_RD_RING_EN
    ring_base = '0;
    ring_words = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", bus.req, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_out_valid", out_valid, 0);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      ack_dly = vecs[i].ackd;
      val_dly = vecs[i].vald;
      grants.delete();
      got.delete();
      d0 = done_cnt;
      do_start(vecs[i].base, vecs[i].cnt);
      wait_done(d0 + 1, 600);
      fa = (grants.size() > 0) ? grants[0] : '1;
      la = (grants.size() > 0) ? grants[grants.size()-1] : '1;
      chk($sformatf("v%0d_first", i), fa, vecs[i].exp_first);
      chk($sformatf("v%0d_last", i), la, vecs[i].exp_last);
      chk($sformatf("v%0d_done_once", i), done_cnt - d0, 1);
      chk($sformatf("v%0d_busy_end", i), busy, 0);
      check_burst($sformatf("v%0d", i), vecs[i].base, int'(vecs[i].cnt));
    end

    // Empty burst: done one cycle after start, no request, never busy.
    d0 = done_cnt;
    req_seen = 0;
    busy_seen = 0;
    @(negedge clk);
    count = '0;
    base_addr = 23'h000777;
    start = 1'b1;
    #2 chk("zero_done_early", done, 0);
    @(negedge clk);
    start = 1'b0;
    #2 chk("zero_done_pulse", done, 1);
    chk("zero_busy", busy, 0);
    @(negedge clk);
    #2 chk("zero_done_width", done, 0);
    repeat (5) @(negedge clk);
    chk("zero_no_req", req_seen, 0);
    chk("zero_no_busy", busy_seen, 0);
    chk("zero_done_count", done_cnt - d0, 1);

    // Credit limit: stalled consumer caps grants at DEPTH; start while busy is ignored.
    ack_dly = 2;
    val_dly = 3;
    grants.delete();
    got.delete();
    out_ready = 1'b0;
    d0 = done_cnt;
    do_start(23'h000800, 16'd20);
    repeat (150) @(negedge clk);
    chk("credit_grants", grants.size(), DEPTH);
    chk("credit_req_low", bus.req, 0);
    chk("credit_out_valid", out_valid, 1);
    chk("credit_busy", busy, 1);
    do_start(23'h000900, 16'd3);
    @(negedge clk);
    out_ready = 1'b1;
    wait_done(d0 + 1, 1500);
    chk("credit_done_once", done_cnt - d0, 1);
    check_burst("credit", 23'h000800, 20);

    // Long withheld grant: req/addr stable, exactly one idle cycle after the ack.
    ack_dly = 50;
    val_dly = 3;
    grants.delete();
    got.delete();
    unstable = 0;
    have_ack = 0;
    gap_meas = -1;
    d0 = done_cnt;
    do_start(23'h001234, 16'd2);
    wait_done(d0 + 1, 600);
    chk("hold_unstable", unstable, 0);
    chk("hold_req_cycles", last_run, 50);
    chk("hold_gap", gap_meas, 1);
    check_burst("hold", 23'h001234, 2);

`ifdef ARB_RD_RING_EN
    ack_dly = 2;
    val_dly = 3;
    grants.delete();
    got.delete();
    ring_base = 23'h000010;
    ring_words = 23'd4;
    d0 = done_cnt;
    do_start(23'h000012, 16'd4);
    wait_done(d0 + 1, 600);
    chk("ring_n", grants.size(), 4);
    if (grants.size() == 4) begin
      chk("ring_a0", grants[0], 23'h000012);
      chk("ring_a1", grants[1], 23'h000013);
      chk("ring_a2", grants[2], 23'h000010);
      chk("ring_a3", grants[3], 23'h000011);
    end
    ring_words = '0;
    ring_base = '0;
`endif

    // Reset with two reads outstanding; their late data must not reach the FIFO.
    ack_dly = 2;
    val_dly = 20;
    grants.delete();
    got.delete();
    do_start(23'h000300, 16'd8);
    begin
      int n = 0;
      while (grants.size() < 2 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("abort_two_grants", grants.size(), 2);
    n_reset = 1'b0;
    #2;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_req", bus.req, 0);
    chk("abort_addr", bus.addr, 0);
    chk("abort_out_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    got.delete();
    repeat (30) @(negedge clk);
    chk("late_valid_out_valid", out_valid, 0);
    chk("late_valid_words", got.size(), 0);
    val_dly = 3;
    grants.delete();
    got.delete();
    d0 = done_cnt;
    do_start(23'h000400, 16'd2);
    wait_done(d0 + 1, 600);
    check_burst("post_reset", 23'h000400, 2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
